if_id_skid_stage: RTL
=====================

Name: if_id_skid_stage

Overview:
- Parametrised successor to the fetch/decode pipeline register.
- Carries {PC, PC+4, instruction} from IF to ID with a valid/ready handshake, a two-entry skid buffer, a flush path that injects a NOP bubble, and a saturating stall-cycle counter.
- Decouples the fetch-side ready from the decode-side stall, so there is no combinational path from STALL to IN_READY.
- Sits between the instruction-memory/PC logic and the decode stage.

Parameters:
- PC_W, 32, width of the PC and PC+4 fields.
- INSTR_W, 32, width of the instruction field.
- NOP_INSTR, 32'h00000013, instruction presented when no valid entry is output (addi x0,x0,0).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- FLUSH  input  1  synchronous squash of all held entries (branch/jump redirect).
- IN_VALID  input  1  fetch side presents a valid instruction.
- IN_READY  output  1  stage can accept; decoded from registered state only.
- PC_IN  input  PC_W  PC of the incoming instruction.
- PC_PLUS_FOUR_IN  input  PC_W  PC+4 of the incoming instruction.
- INSTRUCTION_IN  input  INSTR_W  incoming instruction word.
- STALL  input  1  decode stage cannot accept this cycle (hazard or memory busywait).
- OUT_VALID  output  1  output entry valid.
- PC_OUT  output  PC_W  PC of the output entry.
- PC_PLUS_FOUR_OUT  output  PC_W  PC+4 of the output entry.
- INSTRUCTION_OUT  output  INSTR_W  instruction of the output entry.
- STALL_CNT  output  CNT_W  count of cycles with OUT_VALID=1 and STALL=1.

Behaviour:
- Handshakes:
  - in_fire = IN_VALID & IN_READY.
  - out_fire = OUT_VALID & ~STALL.
- Storage: main register (drives the outputs) and skid register; three states EMPTY, ONE, TWO.
- IN_READY = (state != TWO). OUT_VALID = (state != EMPTY). Both are pure functions of registered state.
- When OUT_VALID=0: INSTRUCTION_OUT=NOP_INSTR, PC_OUT=0, PC_PLUS_FOUR_OUT=0.
- Transitions, evaluated in priority order RESET > FLUSH > normal:
  - EMPTY: in_fire -> ONE, main<=in. Otherwise stay EMPTY.
  - ONE, in_fire & out_fire -> ONE, main<=in.
  - ONE, out_fire only -> EMPTY.
  - ONE, in_fire only (decode stalled) -> TWO, skid<=in, main holds.
  - ONE, neither -> hold.
  - TWO: in_fire is impossible (IN_READY=0). out_fire -> ONE, main<=skid. Otherwise hold.
- Ordering: entries leave in acceptance order; no entry is dropped or duplicated except by FLUSH or RESET.
- Latency: an instruction accepted in cycle N while EMPTY appears at the outputs with OUT_VALID=1 in cycle N+1.
- Throughput: one instruction per cycle with STALL=0 and IN_VALID=1 held.
- FLUSH:
  - Next state EMPTY; main and skid invalidated; outputs show the NOP bubble next cycle.
  - An in_fire in the same cycle as FLUSH is discarded, because the fetched word belongs to the wrong path.
  - IN_READY is 1 in the following cycle.
  - STALL_CNT is unaffected.
- RESET:
  - State EMPTY; all data registers 0 except the output instruction, which shows NOP_INSTR.
  - STALL_CNT=0; IN_READY=1 from the cycle after reset.
  - Reset mid-operation discards all entries, including a full skid.
- STALL_CNT:
  - Increments by 1 on every cycle with OUT_VALID=1 and STALL=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by RESET.
- STALL asserted with OUT_VALID=0 has no effect and is not counted.
- All register updates use nonblocking assignment; no intra-assignment delays.

Test Plan:
- Streaming: reset, then IN_VALID=1 with STALL=0 and PCs 0x0, 0x4, 0x8, 0xC on consecutive cycles -> outputs the same PCs one cycle later, back-to-back with OUT_VALID=1, and PC_PLUS_FOUR_OUT = PC_OUT+4.
- Skid fill: accept PC 0x10, hold STALL=1, and offer PC 0x14 while IN_READY=1.
  - Required: IN_READY=0 next cycle; PC_OUT stays 0x10.
  - Release STALL -> 0x10 then 0x14 appear on consecutive cycles with no loss, and IN_READY returns to 1.
- Flush with full skid: in state TWO, assert FLUSH with IN_VALID=1 and PC 0x40.
  - Required next cycle: OUT_VALID=0, INSTRUCTION_OUT=0x00000013, IN_READY=1.
  - PC 0x40 never appears at the outputs.
- Stall counter: hold a valid entry with STALL=1 for 5 cycles -> STALL_CNT=5.
  - With CNT_W=3, 10 stalled cycles -> STALL_CNT=7 (saturated).
  - FLUSH leaves the count unchanged.
- Reset mid-operation: in state TWO with STALL_CNT=3, assert RESET for one cycle.
  - Required: OUT_VALID=0, PC_OUT=0, INSTRUCTION_OUT=NOP_INSTR, STALL_CNT=0, IN_READY=1.
  - Neither of the held entries is ever output.
- Combinational isolation: toggle STALL in mid-cycle in each state -> IN_READY changes only at clock edges.

Source files
------------

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with a two-entry skid buffer.
//
// Carries {PC, PC+4, instruction} from fetch to decode using a valid/ready
// handshake. IN_READY and OUT_VALID are decoded from registered occupancy
// only, so there is no combinational path from STALL to IN_READY. FLUSH
// squashes every held entry and presents a NOP bubble. STALL_CNT counts
// cycles where a valid entry is held back by STALL, saturating at all-ones.
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   FLUSH               squash all held entries (redirect)
//   IN_VALID/IN_READY   fetch-side handshake
//   PC_IN, PC_PLUS_FOUR_IN, INSTRUCTION_IN   incoming entry
//   STALL               decode cannot accept this cycle
//   OUT_VALID           output entry valid
//   PC_OUT, PC_PLUS_FOUR_OUT, INSTRUCTION_OUT   output entry (bubble if invalid)
//   STALL_CNT           saturating stalled-valid cycle count
module if_id_skid_stage #(
  parameter int unsigned              PC_W      = 32,
  parameter int unsigned              INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]       NOP_INSTR = 32'h0000_0013,
  parameter int unsigned              CNT_W     = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               FLUSH,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [PC_W-1:0]    PC_IN,
  input  logic [PC_W-1:0]    PC_PLUS_FOUR_IN,
  input  logic [INSTR_W-1:0] INSTRUCTION_IN,
  input  logic               STALL,
  output logic               OUT_VALID,
  output logic [PC_W-1:0]    PC_OUT,
  output logic [PC_W-1:0]    PC_PLUS_FOUR_OUT,
  output logic [INSTR_W-1:0] INSTRUCTION_OUT,
  output logic [CNT_W-1:0]   STALL_CNT
);

  localparam int unsigned EntryW = 2 * PC_W + INSTR_W;

  // Entry layout: {pc, pc_plus_four, instruction}
  localparam logic [EntryW-1:0] Bubble = {{(2 * PC_W){1'b0}}, NOP_INSTR};

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [EntryW-1:0]   main_q, main_d;
  logic [EntryW-1:0]   skid_q, skid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                in_fire;
  logic                out_fire;
  logic [EntryW-1:0]   in_entry;

  assign IN_READY  = (state_q != StTwo);
  assign OUT_VALID = (state_q != StEmpty);

  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = OUT_VALID & ~STALL;
  assign in_entry = {PC_IN, PC_PLUS_FOUR_IN, INSTRUCTION_IN};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (FLUSH) begin
      // Any same-cycle in_fire is on the wrong path and is dropped.
      state_d = StEmpty;
      main_d  = Bubble;
      skid_d  = Bubble;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_d  = in_entry;
            state_d = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (out_fire) begin
            state_d = StEmpty;
          end else if (in_fire) begin
            // Decode stalled: park the new entry behind the held one.
            skid_d  = in_entry;
            state_d = StTwo;
          end
        end
        StTwo: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: begin
          state_d = StEmpty;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (OUT_VALID && STALL && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StEmpty;
      main_q  <= Bubble;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    PC_OUT           = '0;
    PC_PLUS_FOUR_OUT = '0;
    INSTRUCTION_OUT  = NOP_INSTR;
    if (OUT_VALID) begin
      {PC_OUT, PC_PLUS_FOUR_OUT, INSTRUCTION_OUT} = main_q;
    end
  end

  assign STALL_CNT = cnt_q;

endmodule
